// File: rtl/rbank_seq.sv
// rbank_seq: serialises operand fetches and writebacks onto the
// single-port register bank, capturing the bank's registered read data.
module rbank_seq #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic        req_two,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [63:0] op_a,
  output logic [63:0] op_b,
  output logic        op_err,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  output logic        rb_we,
  output logic [4:0]  rb_sel,
  output logic [63:0] rb_wdata,
  input  logic [63:0] rb_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_CAP_A = 3'd3;
  localparam logic [2:0] S_CAP_B = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic        two_q, two_d;
  logic [63:0] op_a_q, op_a_d;
  logic [63:0] op_b_q, op_b_d;
  logic        op_err_q, op_err_d;

  logic        wb_win;
  logic        rs1_ok;
  logic        rs2_ok;
  logic        wrd_ok;

  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  assign rs1_ok = in_range(rs1_q);
  assign rs2_ok = in_range(rs2_q);
  assign wrd_ok = in_range(wb_rd);

  assign op_valid = (state_q == S_DONE);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_err   = op_err_q;

  // Handshake readies and bank port drive; writes only in IDLE/DONE
  always_comb begin
    wb_win    = !reset && (state_q == S_IDLE || state_q == S_DONE);
    wb_ready  = wb_win;
    req_ready = !reset && (state_q == S_IDLE) && !wb_valid;
    rb_we     = 1'b0;
    rb_sel    = 5'd0;
    rb_wdata  = 64'd0;
    if (wb_win && wb_valid && wrd_ok) begin
      rb_we    = 1'b1;
      rb_sel   = wb_rd;
      rb_wdata = wb_data;
    end else if (!reset && state_q == S_RD_A) begin
      rb_sel = rs1_q;
    end else if (!reset && state_q == S_RD_B) begin
      rb_sel = rs2_q;
    end
  end

  // Fetch sequencing and operand capture
  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    two_d    = two_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_err_d = op_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          two_d   = req_two;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        state_d = two_q ? S_RD_B : S_CAP_A;
      end
      S_RD_B: begin
        op_a_d   = rs1_ok ? rb_rdata : 64'd0;
        op_err_d = !rs1_ok;
        state_d  = S_CAP_B;
      end
      S_CAP_A: begin
        op_a_d   = rs1_ok ? rb_rdata : 64'd0;
        op_b_d   = 64'd0;
        op_err_d = !rs1_ok;
        state_d  = S_DONE;
      end
      S_CAP_B: begin
        op_b_d   = rs2_ok ? rb_rdata : 64'd0;
        op_err_d = op_err_q | !rs2_ok;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      two_q    <= 1'b0;
      op_a_q   <= 64'd0;
      op_b_q   <= 64'd0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      two_q    <= two_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_err_q <= op_err_d;
    end
  end

endmodule

// File: tb/tb_rbank_seq.sv
// tb_rbank_seq: drives rbank_seq against a behavioural register bank and
// a shadow register-file model; directed steps then random traffic.
module tb_rbank_seq;

  localparam logic [63:0] INIT = 64'h1A1F1A1F1A1F1A1F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic        req_two = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_err;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_data = 64'd0;
  logic        rb_we;
  logic [4:0]  rb_sel;
  logic [63:0] rb_wdata;
  logic [63:0] rb_rdata = 64'd0;

  logic [63:0] bank [16] = '{default: INIT};
  logic [63:0] ref_mem [16] = '{default: INIT};

  int total = 0;
  int bad = 0;

  rbank_seq #(.NUM_REGS(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_two(req_two),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_err(op_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .rb_we(rb_we), .rb_sel(rb_sel), .rb_wdata(rb_wdata),
    .rb_rdata(rb_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural bank: registered read, invalid selects hold rdata
  always @(posedge clk) begin
    if (rb_we) begin
      if (rb_sel < 5'd16) bank[rb_sel[3:0]] <= rb_wdata;
    end else if (rb_sel < 5'd16) begin
      rb_rdata <= bank[rb_sel[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [4:0] idx);
    return (idx < 5'd16) ? ref_mem[idx[3:0]] : 64'd0;
  endfunction

  task automatic wr(input logic [4:0] rd, input logic [63:0] d);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd = rd;
    wb_data = d;
    #1;
    chk("wb_ready", 64'(wb_ready), 64'd1);
    chk("wr_we", 64'(rb_we), 64'(rd < 5'd16));
    if (rd < 5'd16) begin
      chk("wr_sel", 64'(rb_sel), 64'(rd));
      chk("wr_data", rb_wdata, d);
    end
    @(posedge clk);
    if (rd < 5'd16) ref_mem[rd[3:0]] = d;
    #1 wb_valid = 1'b0;
  endtask

  task automatic fetch(input logic [4:0] a, input logic [4:0] b,
                       input logic two, input int hold,
                       input logic dowr, input logic [4:0] wrd,
                       input logic [63:0] wdat);
    logic [63:0] ea, eb;
    logic ee, busy_ok;
    int k, lat;
    ea = model_rd(a);
    eb = two ? model_rd(b) : 64'd0;
    ee = (a >= 5'd16) || (two && b >= 5'd16);
    lat = two ? 4 : 3;
    @(negedge clk);
    req_valid = 1'b1;
    req_rs1 = a;
    req_rs2 = b;
    req_two = two;
    #1;
    chk("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("rd_a_sel", 64'(rb_sel), 64'(a));
      if (!op_valid && (wb_ready || rb_we)) busy_ok = 1'b0;
    end while (!op_valid && k < 20);
    chk("latency", 64'(k), 64'(lat));
    chk("busy_no_wb", 64'(busy_ok), 64'd1);
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("op_err", 64'(op_err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && dowr) begin
        wb_valid = 1'b1;
        wb_rd = wrd;
        wb_data = wdat;
        #1 chk("done_wb_ready", 64'(wb_ready), 64'd1);
        @(posedge clk);
        if (wrd < 5'd16) ref_mem[wrd[3:0]] = wdat;
        #1 wb_valid = 1'b0;
      end
      @(negedge clk);
      chk("hold_valid", 64'(op_valid), 64'd1);
      chk("hold_a", op_a, ea);
      chk("hold_b", op_b, eb);
    end
    op_ready = 1'b1;
    @(posedge clk);
    #1 op_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", 64'(op_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_a", op_a, 64'd0);
    chk("rst_op_b", op_b, 64'd0);
    chk("rst_op_err", 64'(op_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd0);
    chk("rst_rb_we", 64'(rb_we), 64'd0);
    chk("rst_rb_sel", 64'(rb_sel), 64'd0);
    chk("rst_rb_wdata", rb_wdata, 64'd0);
    reset = 1'b0;

    // two-operand fetch of untouched registers
    fetch(5'd0, 5'd15, 1'b1, 0, 1'b0, 5'd0, 64'd0);
    chk("init_pattern", ref_mem[0], INIT);

    // write then single-operand fetch
    wr(5'd3, 64'hDEADBEEF00000001);
    fetch(5'd3, 5'd0, 1'b0, 0, 1'b0, 5'd0, 64'd0);

    // simultaneous writeback and request: writeback wins
    @(negedge clk);
    req_valid = 1'b1;
    req_rs1 = 5'd13;
    req_two = 1'b0;
    wb_valid = 1'b1;
    wb_rd = 5'd13;
    wb_data = 64'h55;
    #1;
    chk("prio_req_ready", 64'(req_ready), 64'd0);
    chk("prio_wb_ready", 64'(wb_ready), 64'd1);
    chk("prio_rb_we", 64'(rb_we), 64'd1);
    @(posedge clk);
    ref_mem[13] = 64'h55;
    #1 wb_valid = 1'b0;
    fetch(5'd13, 5'd0, 1'b0, 0, 1'b0, 5'd0, 64'd0);
    chk("a5_model", ref_mem[13], 64'h55);

    // out-of-range source and destination
    fetch(5'd2, 5'd20, 1'b1, 0, 1'b0, 5'd0, 64'd0);
    wr(5'd31, 64'hCAFE);
    fetch(5'd16, 5'd1, 1'b1, 0, 1'b0, 5'd0, 64'd0);

    // long hold in DONE with a write to rs1
    fetch(5'd4, 5'd5, 1'b1, 10, 1'b1, 5'd4, 64'h1234_5678_9ABC_DEF0);
    fetch(5'd4, 5'd0, 1'b0, 0, 1'b0, 5'd0, 64'd0);

    // reset during RD_B
    @(negedge clk);
    req_valid = 1'b1;
    req_rs1 = 5'd6;
    req_rs2 = 5'd7;
    req_two = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstb_rb_we", 64'(rb_we), 64'd0);
    chk("rstb_wb_ready", 64'(wb_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstb_op_valid", 64'(op_valid), 64'd0);
    chk("rstb_op_a", op_a, 64'd0);
    chk("rstb_idle", 64'(req_ready), 64'd1);
    fetch(5'd6, 5'd7, 1'b1, 0, 1'b0, 5'd0, 64'd0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr(5'($urandom_range(0, 19)), {$urandom, $urandom});
      end else begin
        fetch(5'($urandom_range(0, 17)), 5'($urandom_range(0, 17)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)),
              {$urandom, $urandom});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbank_seq.md
# rbank_seq

Register-bank access sequencer: the initiator that drives the single-port processor register bank's select/write-enable/data port on behalf of the pipeline. It accepts operand-fetch requests (one or two source indices) and writeback requests over valid/ready handshakes. It serialises them onto the bank port, accounting for the bank's one-cycle registered read, and returns captured 64-bit operands. It sits between decode/execute and the register bank.

## Interface
- NUM_REGS, 16: number of implemented bank registers; indices 0..NUM_REGS-1 valid (g0-g7 = 0-7, a0-a7 = 8-15).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  operand-fetch request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rs1  in  5  first source index.
- req_rs2  in  5  second source index.
- req_two  in  1  1 = fetch rs1 and rs2; 0 = fetch rs1 only.
- op_valid  out  1  operands valid; held until op_ready.
- op_ready  in  1  consumer accepts operands.
- op_a  out  64  value of rs1.
- op_b  out  64  value of rs2 (0 when req_two=0).
- op_err  out  1  a requested source index was >= NUM_REGS.
- wb_valid  in  1  writeback valid.
- wb_ready  out  1  writeback accepted when wb_valid && wb_ready.
- wb_rd  in  5  destination index.
- wb_data  in  64  writeback data.
- rb_we  out  1  bank write enable.
- rb_sel  out  5  bank register select.
- rb_wdata  out  64  bank write data.
- rb_rdata  in  64  bank read data; reflects rb_sel of the previous cycle when rb_we was 0.

## Operation
- States: IDLE, RD_A, RD_B, CAP_A, CAP_B, DONE.
- IDLE: wb_ready=1. req_ready = !wb_valid, so writeback has priority and a request is never accepted in a cycle carrying a writeback. On request handshake, latch rs1, rs2 and req_two, then go to RD_A.
- RD_A: rb_sel=rs1, rb_we=0. Next state is RD_B if req_two, else CAP_A.
- RD_B: capture op_a from rb_rdata, drive rb_sel=rs2, rb_we=0, then go to CAP_B.
- CAP_B: capture op_b from rb_rdata, then go to DONE.
- CAP_A: capture op_a from rb_rdata, set op_b=0, then go to DONE.
- DONE: op_valid=1 and op_a/op_b/op_err stable. On op_ready, go to IDLE. wb_ready=1 here: a write updates the bank but does not alter the held operands.
- Writeback (IDLE or DONE): in the handshake cycle, rb_we=1, rb_sel=wb_rd, rb_wdata=wb_data. Back-to-back writes are allowed every cycle.
- wb_ready=0 in RD_A, RD_B, CAP_A and CAP_B, so the bank port is never written during a read.
- Out-of-range source (>= NUM_REGS): the bank holds rb_rdata for invalid selects, so the sequencer forces that operand to 0 and sets op_err=1. The state sequence and latency are unchanged.
- Out-of-range wb_rd: the handshake completes, rb_we stays 0, and the data is dropped.
- When not writing, rb_sel=0 and rb_wdata=0 in IDLE/DONE.

## Timing
- Reset values: op_valid=0, op_a=0, op_b=0, op_err=0, req_ready=0, wb_ready=0, rb_we=0, rb_sel=0, rb_wdata=0. State is IDLE.
- rb_* outputs and the ready signals are combinational from state and inputs. op_* are registered.
- Two-operand request accepted at cycle T: RD_A at T+1, RD_B at T+2, CAP_B at T+3, op_valid at T+4.
- Single-operand request accepted at T: op_valid at T+3.
- Minimum request throughput is 1 per 5 cycles (two operands) or 1 per 4 cycles (single operand), with op_ready held high.
- Read-after-write: a write accepted at cycle W is visible to any request accepted at or after W+1.
- Reset asserted in any state: the next state is IDLE and all outputs take their reset values. An in-flight fetch is abandoned, and no write is issued in the reset cycle.
- A continuous wb_valid stream starves requests. This is intentional; upstream bounds it.

## Test plan
- Reset, then a two-operand fetch of rs1=0, rs2=15 with no prior writes -> op_a=op_b=64'h1A1F1A1F1A1F1A1F, op_err=0, op_valid exactly 4 cycles after acceptance.
- Write g3=64'hDEADBEEF00000001, then next cycle fetch rs1=3, req_two=0 -> op_a=64'hDEADBEEF00000001, op_b=0, op_valid 3 cycles after acceptance.
- wb_valid and req_valid both asserted in IDLE (write a5=64'h55) -> write accepted, req_ready=0 that cycle; request accepted the next cycle returns the new a5 value 64'h55.
- Fetch rs1=2, rs2=20 -> op_a = g2, op_b=0, op_err=1. Write to rd=31 -> wb_ready=1, rb_we never asserted.
- op_ready held low for 10 cycles in DONE, with a write to rs1 during that window -> op_valid, op_a and op_b remain stable and reflect the pre-write values; returns to IDLE one cycle after op_ready=1.
- Reset asserted during RD_B -> next cycle IDLE, op_valid=0, rb_we=0; a subsequent fetch completes normally.
